data_mem_stage: RTL and testbench

Memory-access stage of the 32-bit RISC-V core. It sits directly downstream of the ALU, which is the execute stage. The ALU result is used as the effective address for loads and stores, or passed straight through for non-memory instructions. The stage drives a single-outstanding request/grant/response data bus, performs byte-lane steering and load sign/zero extension, detects misalignment, and stalls the execute stage while a bus transaction is in flight.

---
 rtl/data_mem_stage.sv | 171 +++++++++++++++++
 tb/tb_data_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// Memory-access stage: drives a single-outstanding req/gnt/rvalid data bus,
// steers store lanes, extends load data, flags misaligned/illegal accesses.
module data_mem_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ex_aluout,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic                      ex_memread,
  input  logic                      ex_memwrite,
  input  logic [2:0]                ex_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_regwrite,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [3:0]                mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_regwrite,
  output logic                      wb_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                    state;
  logic [1:0]                addr_lo;
  logic [2:0]                funct3_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      regwrite_q;

  // Illegal size for the access kind, misalignment, or read+write together.
  function automatic logic access_fault(input logic rd_op, input logic wr_op,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = wr_op;
      3'b101:  bad = wr_op | a[0];
      default: bad = 1'b1;
    endcase
    return bad | (rd_op & wr_op);
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = 16'(d >> {a[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h000000, b};
      3'b101:  return {16'h0000, h};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ex_ready    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 4'b0000;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      wb_fault    <= 1'b0;
      addr_lo     <= 2'b00;
      funct3_q    <= 3'b000;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            addr_lo    <= ex_aluout[1:0];
            funct3_q   <= ex_funct3;
            rd_q       <= ex_rd;
            regwrite_q <= ex_regwrite;
            wb_rd      <= ex_rd;
            if (!(ex_memread || ex_memwrite)) begin
              wb_valid    <= 1'b1;
              wb_data     <= ex_aluout;
              wb_regwrite <= ex_regwrite;
              wb_fault    <= 1'b0;
            end else if (access_fault(ex_memread, ex_memwrite, ex_funct3, ex_aluout[1:0])) begin
              wb_valid    <= 1'b1;
              wb_data     <= ex_aluout;
              wb_regwrite <= 1'b0;
              wb_fault    <= 1'b1;
            end else begin
              state     <= REQ;
              ex_ready  <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= ex_memwrite;
              mem_addr  <= {ex_aluout[31:2], 2'b00};
              mem_be    <= lane_be(ex_funct3, ex_aluout[1:0]);
              mem_wdata <= lane_wdata(ex_funct3, ex_wdata);
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state       <= IDLE;
              ex_ready    <= 1'b1;
              wb_valid    <= 1'b1;
              wb_data     <= {mem_addr[31:2], addr_lo};
              wb_rd       <= rd_q;
              wb_regwrite <= 1'b0;
              wb_fault    <= 1'b0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state       <= IDLE;
            ex_ready    <= 1'b1;
            wb_valid    <= 1'b1;
            wb_data     <= load_extend(funct3_q, addr_lo, mem_rdata);
            wb_rd       <= rd_q;
            wb_regwrite <= regwrite_q;
            wb_fault    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ex_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: ALU pass-through, stores, loads, faults, reset.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_aluout;
  logic [31:0] ex_wdata;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        wb_fault;

  int checks   = 0;
  int failures = 0;

  data_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluout(ex_aluout), .ex_wdata(ex_wdata),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw);
    ex_valid = 1'b1; ex_memread = rd_op; ex_memwrite = wr_op; ex_funct3 = f3;
    ex_aluout = addr; ex_wdata = wd; ex_rd = rd; ex_regwrite = rw;
  endtask

  // Load with immediate grant and response; returns the written-back data.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         output logic [31:0] result);
    present(1'b1, 1'b0, f3, addr, 32'h0, 5'd4, 1'b1);
    step();
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
    result = wb_data;
    step();
  endtask

  logic [31:0] res;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_aluout = '0; ex_wdata = '0; ex_memread = 1'b0;
    ex_memwrite = 1'b0; ex_funct3 = 3'b000; ex_rd = '0; ex_regwrite = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);

    // ALU pass-through
    present(1'b0, 1'b0, 3'b000, 32'h0000_002A, 32'h0, 5'd5, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_data", wb_data, 32'h2A);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_regwrite", 32'(wb_regwrite), 32'd1);
    chk("alu_ex_ready", 32'(ex_ready), 32'd1);
    step();
    chk("alu_wb_pulse", 32'(wb_valid), 32'd0);

    // Back-to-back ALU ops
    present(1'b0, 1'b0, 3'b000, 32'h11, 32'h0, 5'd1, 1'b1);
    step();
    present(1'b0, 1'b0, 3'b000, 32'h22, 32'h0, 5'd2, 1'b0);
    chk("b2b_first", wb_data, 32'h11);
    step();
    ex_valid = 1'b0;
    chk("b2b_second_valid", 32'(wb_valid), 32'd1);
    chk("b2b_second_data", wb_data, 32'h22);
    chk("b2b_second_rw", 32'(wb_regwrite), 32'd0);
    step();

    // SB, grant two cycles late
    present(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 5'd6, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("sb_req", 32'(mem_req), 32'd1);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_stall", 32'(ex_ready), 32'd0);
    step();
    step();
    chk("sb_req_held", 32'(mem_req), 32'd1);
    chk("sb_no_wb", 32'(wb_valid), 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sb_req_drop", 32'(mem_req), 32'd0);
    chk("sb_wb_valid", 32'(wb_valid), 32'd1);
    chk("sb_wb_rw", 32'(wb_regwrite), 32'd0);
    chk("sb_ready", 32'(ex_ready), 32'd1);
    step();

    // SH to upper half
    present(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0, 1'b0);
    step();
    ex_valid = 1'b0;
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();

    // LB with a spurious rvalid in the grant cycle and one idle WAIT cycle
    present(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 5'd7, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_addr", mem_addr, 32'h100);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("lb_req_drop", 32'(mem_req), 32'd0);
    chk("lb_stall", 32'(ex_ready), 32'd0);
    step();
    chk("lb_gnt_rvalid_ignored", 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000;
    step();
    mem_rvalid = 1'b0;
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_rd", 32'(wb_rd), 32'd7);
    chk("lb_rw", 32'(wb_regwrite), 32'd1);
    step();

    do_load(3'b100, 32'h0000_0102, 32'h0080_0000, res);
    chk("lbu_data", res, 32'h0000_0080);
    do_load(3'b001, 32'h0000_0102, 32'h8001_0000, res);
    chk("lh_data", res, 32'hFFFF_8001);
    do_load(3'b101, 32'h0000_0102, 32'h8001_0000, res);
    chk("lhu_data", res, 32'h0000_8001);
    do_load(3'b010, 32'h0000_0104, 32'h1357_9BDF, res);
    chk("lw_data", res, 32'h1357_9BDF);

    // Misaligned LH
    present(1'b1, 1'b0, 3'b001, 32'h0000_0201, 32'h0, 5'd8, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("lh_mis_valid", 32'(wb_valid), 32'd1);
    chk("lh_mis_fault", 32'(wb_fault), 32'd1);
    chk("lh_mis_rw", 32'(wb_regwrite), 32'd0);
    chk("lh_mis_data", wb_data, 32'h201);
    chk("lh_mis_noreq", 32'(mem_req), 32'd0);
    step();
    chk("lh_mis_noreq2", 32'(mem_req), 32'd0);

    // Misaligned SW, store with unsigned size, read+write together
    present(1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'h0, 5'd0, 1'b0);
    step();
    chk("sw_mis_fault", 32'(wb_fault), 32'd1);
    present(1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h0, 5'd0, 1'b0);
    step();
    chk("sbu_fault", 32'(wb_fault), 32'd1);
    present(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd3, 1'b1);
    step();
    ex_valid = 1'b0;
    chk("rdwr_fault", 32'(wb_fault), 32'd1);
    chk("rdwr_noreq", 32'(mem_req), 32'd0);
    step();

    // LW abandoned by reset in WAIT; late gnt/rvalid ignored
    present(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd10, 1'b1);
    step();
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstw_wb_data", wb_data, 32'h0);
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'h0);
    chk("rstw_ex_ready", 32'(ex_ready), 32'd1);

    // ALU op held off while a load waits for its response
    present(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9, 1'b1);
    step();
    mem_gnt = 1'b1;
    present(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3, 1'b1);
    step();
    mem_gnt = 1'b0;
    chk("hold_ready_low", 32'(ex_ready), 32'd0);
    step();
    chk("hold_not_accepted", 32'(wb_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("hold_load_data", wb_data, 32'hCAFE_F00D);
    chk("hold_load_rd", 32'(wb_rd), 32'd9);
    chk("hold_ready_high", 32'(ex_ready), 32'd1);
    step();
    ex_valid = 1'b0;
    chk("hold_alu_valid", 32'(wb_valid), 32'd1);
    chk("hold_alu_data", wb_data, 32'h55);
    chk("hold_alu_rd", 32'(wb_rd), 32'd3);
    step();
    chk("hold_final_idle", 32'(wb_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
